// File: rtl/flappy_pkg.sv
// -----------------------------------------------------------------------------
// flappy_pkg
//   Definitions shared by controller, view and score_keeper.
//   - scene encoding driven by controller
//   - bird column and number of pipe records on the pipes bus
//   - bit positions of the fields inside one 24-bit pipe record
//   - packed-BCD limit of the 3-digit score
// -----------------------------------------------------------------------------
package flappy_pkg;

   // Scene code 3 is reserved; consumers treat it as GAMEOVER.
   typedef enum logic [1:0] {
      SCENE_SPLASH   = 2'd0,
      SCENE_PLAYING  = 2'd1,
      SCENE_GAMEOVER = 2'd2
   } scene_e;

   localparam int unsigned BIRD_COL = 10;
   localparam int unsigned N_PIPE   = 3;
   localparam int unsigned PIPE_W   = 24;

   // One pipe record is {pos[7:0], max[7:0], min[7:0]}; record 0 is the leading pipe.
   localparam int unsigned POS_MSB = 23;
   localparam int unsigned POS_LSB = 16;
   localparam int unsigned MAX_MSB = 15;
   localparam int unsigned MAX_LSB = 8;
   localparam int unsigned MIN_MSB = 7;
   localparam int unsigned MIN_LSB = 0;

   localparam logic [11:0] BCD_MAX = 12'h999;

endpackage : flappy_pkg

// File: rtl/bcd_inc3.sv
// -----------------------------------------------------------------------------
// bcd_inc3
//   Combinational 3-digit packed-BCD incrementer.
//   Ports:
//     d   [11:0] in  : value {hundreds, tens, ones}, every nibble 0..9
//     q   [11:0] out : d + 1 in BCD; equals d when d is already 999
//     sat        out : d is at the 3-digit maximum (999)
// -----------------------------------------------------------------------------
module bcd_inc3
   import flappy_pkg::*;
(
   input  logic [11:0] d,
   output logic [11:0] q,
   output logic        sat
);

   always_comb begin
      // NOTE: every output gets a value before any branch, so no path can leave it unassigned and infer a latch.
      sat = (d == BCD_MAX);
      q   = d;
      if (!sat) begin
         if (d[3:0] != 4'd9) begin
            q[3:0] = d[3:0] + 4'd1;
         end else begin
            q[3:0] = 4'd0;
            if (d[7:4] != 4'd9) begin
               q[7:4] = d[7:4] + 4'd1;
            end else begin
               // Not saturated, so hundreds is below 9 and cannot overflow here.
               q[7:4]  = 4'd0;
               q[11:8] = d[11:8] + 4'd1;
            end
         end
      end
   end

endmodule : bcd_inc3

// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
//   Counts pipes cleared by the bird during play and keeps the best score of
//   the session, both as 3-digit packed BCD. Observes controller outputs only.
//   Ports:
//     clk                 in  : system clock (shared with controller/view)
//     rst                 in  : asynchronous active-high reset
//     scene      [1:0]    in  : SPLASH/PLAYING/GAMEOVER (3 behaves as GAMEOVER)
//     pipes      [24*N-1:0] in: pipe records, record 0 at [23:0] is the leader
//     score_bcd  [11:0]   out : current score, packed BCD
//     best_bcd   [11:0]   out : best score since reset, packed BCD
//     score_tick          out : one-cycle pulse with each score increment
//     new_best            out : current/finished game beats the prior best
// -----------------------------------------------------------------------------
module score_keeper
   import flappy_pkg::*;
#(
   parameter int unsigned N_PIPE    = flappy_pkg::N_PIPE,
   parameter logic [7:0]  PASS_COL  = 8'(flappy_pkg::BIRD_COL - 7),
   parameter logic [11:0] SCORE_MAX = 12'h999
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            scene,
   input  logic [24*N_PIPE-1:0]  pipes,
   output logic [11:0]           score_bcd,
   output logic [11:0]           best_bcd,
   output logic                  score_tick,
   output logic                  new_best
);

   logic [1:0]  prev_scene_q,    prev_scene_d;
   logic [7:0]  prev_pos_q,      prev_pos_d;
   logic [11:0] score_q,         score_d;
   logic [11:0] best_q,          best_d;
   logic [11:0] best_at_start_q, best_at_start_d;
   logic        score_tick_q,    score_tick_d;
   logic        new_best_q,      new_best_d;
   // prev_valid: prev_scene holds a sampled scene, not just its reset value.
   // armed: a real SPLASH->PLAYING start has been seen since reset.
   // Together they stop a reset in the middle of PLAYING from looking like a
   // start edge, so scoring resumes only after a genuine new game begins.
   logic        prev_valid_q,    prev_valid_d;
   logic        armed_q,         armed_d;

   logic [7:0]  lead_pos;
   logic [11:0] score_inc;
   logic        inc_sat;
   logic        at_max;
   logic        start_edge;
   logic        pass_event;
   logic        end_edge;

   // Only the leading pipe position matters; the remaining record fields are
   // the renderer's business.
   logic        unused_pipe_bits;
   assign unused_pipe_bits = ^pipes;

   bcd_inc3 u_inc (
      .d   (score_q),
      .q   (score_inc),
      .sat (inc_sat)
   );

   always_comb begin
      lead_pos   = pipes[POS_MSB:POS_LSB];
      at_max     = inc_sat || (score_q == SCORE_MAX);
      start_edge = prev_valid_q && (prev_scene_q == SCENE_SPLASH) && (scene == SCENE_PLAYING);
      // The leader sits on each column for several cycles; only the first
      // cycle at PASS_COL counts. A wrap to a far position never hits it.
      pass_event = armed_q && (scene == SCENE_PLAYING) && (prev_scene_q == SCENE_PLAYING) &&
                   (lead_pos == PASS_COL) && (prev_pos_q != PASS_COL);
      end_edge   = (prev_scene_q == SCENE_PLAYING) && (scene != SCENE_PLAYING);

      prev_scene_d    = scene;
      prev_pos_d      = lead_pos;
      prev_valid_d    = 1'b1;
      armed_d         = armed_q;
      score_d         = score_q;
      best_d          = best_q;
      best_at_start_d = best_at_start_q;
      score_tick_d    = 1'b0;
      new_best_d      = new_best_q;

      // A start edge outranks a pass in the same cycle.
      if (start_edge) begin
         score_d         = 12'h000;
         best_at_start_d = best_q;
         new_best_d      = 1'b0;
         armed_d         = 1'b1;
      end else if (pass_event && !at_max) begin
         score_d      = score_inc;
         score_tick_d = 1'b1;
         // Packed BCD orders the same way as plain unsigned binary.
         if (score_inc > best_at_start_q) begin
            new_best_d = 1'b1;
         end
      end

      // Score itself is held after the game so view can show it.
      if (end_edge && (score_q > best_q)) begin
         best_d = score_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_scene_q    <= SCENE_SPLASH;
         prev_pos_q      <= 8'hFF;
         prev_valid_q    <= 1'b0;
         armed_q         <= 1'b0;
         score_q         <= 12'h000;
         best_q          <= 12'h000;
         best_at_start_q <= 12'h000;
         score_tick_q    <= 1'b0;
         new_best_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every flop samples the pre-edge values computed in always_comb.
         prev_scene_q    <= prev_scene_d;
         prev_pos_q      <= prev_pos_d;
         prev_valid_q    <= prev_valid_d;
         armed_q         <= armed_d;
         score_q         <= score_d;
         best_q          <= best_d;
         best_at_start_q <= best_at_start_d;
         score_tick_q    <= score_tick_d;
         new_best_q      <= new_best_d;
      end
   end

   assign score_bcd  = score_q;
   assign best_bcd   = best_q;
   assign score_tick = score_tick_q;
   assign new_best   = new_best_q;

endmodule : score_keeper

// File: tb/tb_score_keeper.sv
// -----------------------------------------------------------------------------
// tb_score_keeper
//   Randomized pipe traffic against an integer reference model of the score
//   rules. Each expected score tick is queued by the stimulus; a monitor
//   consumes the queue whenever the DUT pulses score_tick.
// -----------------------------------------------------------------------------
module tb_score_keeper;
   import flappy_pkg::*;

   localparam logic [7:0] PASS = 8'd3;

   logic        clk;
   logic        rst;
   logic [1:0]  scene;
   logic [71:0] pipes;
   logic [11:0] score_bcd;
   logic [11:0] best_bcd;
   logic        score_tick;
   logic        new_best;

   score_keeper dut (
      .clk        (clk),
      .rst        (rst),
      .scene      (scene),
      .pipes      (pipes),
      .score_bcd  (score_bcd),
      .best_bcd   (best_bcd),
      .score_tick (score_tick),
      .new_best   (new_best)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [11:0] score;
      logic        nb;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model state: plain integers, scene history and a run flag.
   int          m_score;
   int          m_best;
   int          m_bas;
   bit          m_nb;
   bit          m_armed;
   bit          m_valid;
   logic [1:0]  m_last_scene;
   logic [7:0]  m_last_pos;

   function automatic logic [11:0] to_bcd(input int v);
      logic [3:0] h, t, o;
      h = 4'(v / 100);
      t = 4'((v / 10) % 10);
      o = 4'(v % 10);
      return {h, t, o};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_score      = 0;
      m_best       = 0;
      m_bas        = 0;
      m_nb         = 1'b0;
      m_armed      = 1'b0;
      m_valid      = 1'b0;
      m_last_scene = SCENE_SPLASH;
      m_last_pos   = 8'hFF;
   endtask

   // Drive one cycle of inputs (called at posedge+1) and advance the model.
   task automatic step(input logic [1:0] sc, input logic [7:0] pos);
      logic [71:0] r;
      bit          play_now;
      exp_t        e;
      for (int b = 0; b < 9; b++) r[b*8 +: 8] = 8'($urandom);
      r[23:16] = pos;
      pipes    = r;
      scene    = sc;
      play_now = (sc == SCENE_PLAYING);
      if (m_valid && m_last_scene == SCENE_SPLASH && play_now) begin
         m_score = 0;
         m_bas   = m_best;
         m_nb    = 1'b0;
         m_armed = 1'b1;
      end else if (m_armed && play_now && m_last_scene == SCENE_PLAYING &&
                   pos == PASS && m_last_pos != PASS && m_score < 999) begin
         m_score++;
         if (m_score > m_bas) m_nb = 1'b1;
         e.score = to_bcd(m_score);
         e.nb    = m_nb;
         e.cyc   = cyc + 1;
         exp_q.push_back(e);
      end
      if (m_last_scene == SCENE_PLAYING && !play_now && m_score > m_best) m_best = m_score;
      m_last_scene = sc;
      m_last_pos   = pos;
      m_valid      = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic pass_pipe();
      step(SCENE_PLAYING, 8'(4 + $urandom_range(0, 40)));
      step(SCENE_PLAYING, PASS);
   endtask

   // Random pipe motion: variable hold times and occasional wrap-around.
   task automatic random_pipe();
      int h;
      if ($urandom_range(0, 7) == 0) begin
         h = $urandom_range(1, 3);
         repeat (h) step(SCENE_PLAYING, 8'd0);
         step(SCENE_PLAYING, 8'($urandom_range(50, 255)));
      end
      h = $urandom_range(1, 3);
      repeat (h) step(SCENE_PLAYING, 8'($urandom_range(4, 49)));
      h = $urandom_range(1, 3);
      repeat (h) step(SCENE_PLAYING, PASS);
      step(SCENE_PLAYING, 8'($urandom_range(0, 2)));
   endtask

   task automatic start_game();
      step(SCENE_SPLASH, 8'd60);
      step(SCENE_PLAYING, 8'd60);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 6; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
         #1;
      end
      check(name, exp_q.size(), 0);
   endtask

   task automatic assert_reset();
      rst = 1'b1;
      #1;
      check("rst_score", score_bcd, 12'h000);
      check("rst_best", best_bcd, 12'h000);
      check("rst_tick", score_tick, 1'b0);
      check("rst_new_best", new_best, 1'b0);
      model_reset();
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Monitor: every DUT tick must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && score_tick) begin
         if (exp_q.size() == 0) begin
            check("spurious_tick", score_tick, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check("tick_score", score_bcd, e.score);
            check("tick_new_best", new_best, e.nb);
            check("tick_latency", cyc, e.cyc);
            check("tick_nibbles", (score_bcd[3:0] <= 4'd9) && (score_bcd[7:4] <= 4'd9) &&
                  (score_bcd[11:8] <= 4'd9), 1'b1);
         end
      end
   end

   initial begin
      rst   = 1'b1;
      scene = SCENE_SPLASH;
      pipes = '0;
      pipes[23:16] = PASS;
      model_reset();
      #2;
      check("reset_score", score_bcd, 12'h000);
      check("reset_best", best_bcd, 12'h000);
      check("reset_tick", score_tick, 1'b0);
      check("reset_new_best", new_best, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // SPLASH with the leader crossing PASS_COL: nothing scores.
      repeat (4) begin
         step(SCENE_SPLASH, 8'd4);
         step(SCENE_SPLASH, PASS);
      end
      check("splash_score", score_bcd, 12'h000);
      check("splash_best", best_bcd, 12'h000);
      check("splash_new_best", new_best, 1'b0);

      // First game: the stepped leader sequence yields exactly one point.
      start_game();
      foreach (pipes[i]) begin end
      begin
         logic [7:0] seq [10] = '{8'd5, 8'd5, 8'd5, 8'd4, 8'd4, 8'd4, 8'd3, 8'd3, 8'd3, 8'd2};
         foreach (seq[i]) step(SCENE_PLAYING, seq[i]);
      end
      drain("drain_first");
      check("first_score", score_bcd, 12'h001);

      // Random traffic up to 99, then the carry into hundreds.
      while (m_score < 99) random_pipe();
      drain("drain_99");
      check("score_99", score_bcd, 12'h099);
      pass_pipe();
      drain("drain_100");
      check("score_100", score_bcd, 12'h100);

      // Run to saturation; further passes neither count nor tick.
      while (m_score < 999) pass_pipe();
      drain("drain_999");
      check("score_999", score_bcd, 12'h999);
      repeat (3) pass_pipe();
      repeat (3) step(SCENE_PLAYING, 8'd20);
      check("sat_hold", score_bcd, 12'h999);
      check("sat_tick", score_tick, 1'b0);
      step(SCENE_GAMEOVER, 8'd20);
      check("sat_best", best_bcd, to_bcd(m_best));
      check("sat_score_held", score_bcd, 12'h999);

      // Clean session for the best-score games.
      assert_reset();
      step(SCENE_SPLASH, 8'd30);

      start_game();
      while (m_score < 5) random_pipe();
      drain("drain_g1");
      step(SCENE_GAMEOVER, 8'd20);
      check("g1_best", best_bcd, 12'h005);
      check("g1_model_best", best_bcd, to_bcd(m_best));
      check("g1_new_best", new_best, 1'b1);

      start_game();
      while (m_score < 3) pass_pipe();
      drain("drain_g2");
      step(SCENE_GAMEOVER, 8'd20);
      check("g2_best", best_bcd, 12'h005);
      check("g2_new_best", new_best, 1'b0);
      check("g2_score_held", score_bcd, 12'h003);
      step(SCENE_SPLASH, 8'd20);
      check("g2_score_splash", score_bcd, 12'h003);

      start_game();
      check("g3_start_clear", score_bcd, 12'h000);
      while (m_score < 6) pass_pipe();
      drain("drain_g3");
      step(SCENE_GAMEOVER, 8'd20);
      check("g3_best", best_bcd, 12'h006);
      check("g3_new_best", new_best, 1'b1);

      // Reset in the middle of a game, then passes without a new start.
      start_game();
      while (m_score < 4) pass_pipe();
      drain("drain_g4");
      check("g4_score", score_bcd, 12'h004);
      check("g4_new_best", new_best, 1'b0);
      assert_reset();
      repeat (5) pass_pipe();
      repeat (2) step(SCENE_PLAYING, 8'd20);
      check("post_rst_score", score_bcd, 12'h000);
      check("post_rst_best", best_bcd, 12'h000);
      check("post_rst_tick_q", exp_q.size(), 0);

      // A genuine start edge re-enables scoring.
      start_game();
      repeat (2) random_pipe();
      drain("drain_resume");
      check("resume_score", score_bcd, to_bcd(m_score));
      check("resume_new_best", new_best, m_nb);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_score_keeper

// File: doc/score_keeper.md
# score_keeper

Counts pipes cleared by the bird during play and keeps the session best score, both as 3-digit packed BCD. Sits directly downstream of `controller`, in parallel with `view`. It consumes `scene` and the packed `pipes` bus and feeds score digits to the renderer. Purely observational: it never drives back into `controller`.

## Interface

Parameters:
- `N_PIPE`, 3: number of 24-bit pipe records on `pipes`.
- `PASS_COL`, 8'd3: leading-pipe position at which the pipe counts as cleared (`BIRD_COL` − 7, one column past the collision window).
- `SCORE_MAX`, 12'h999: BCD saturation value.

Ports:
- `clk`, input, 1: system clock, the same clock as `controller`/`view`.
- `rst`, input, 1: asynchronous, active-high reset.
- `scene`, input, 2: SPLASH=0, PLAYING=1, GAMEOVER=2 (3 is reserved and treated as GAMEOVER).
- `pipes`, input, 24*N_PIPE: pipe records as `{pos[7:0], max[7:0], min[7:0]}`, record 0 at bits [23:0] = leading pipe.
- `score_bcd`, output, 12: current score, packed BCD {hundreds, tens, ones}.
- `best_bcd`, output, 12: best score since reset, packed BCD.
- `score_tick`, output, 1: one-cycle pulse, registered with the `score_bcd` update.
- `new_best`, output, 1: high while the finished or current game beats the prior best.

## Operation

- Registers: `prev_scene[1:0]`, `prev_pos[7:0]`, `score`, `best`, `best_at_start`, `score_tick`, `new_best`.
- `lead_pos = pipes[23:16]`.
- Pass event: `scene==PLAYING && prev_scene==PLAYING && lead_pos==PASS_COL && prev_pos!=PASS_COL`.
  - The leading position holds for 3 cycles per step, so edge detection yields exactly one event per pipe.
  - Wrap-around (lead reaches 0, the records shift, and the new lead is ≥ 50) produces no event.
- Start edge: `prev_scene==SPLASH && scene==PLAYING`.
  - `score` ← 0, `best_at_start` ← `best`, `new_best` ← 0.
  - A pass event in the same cycle is ignored. The start edge wins.
- Pass event:
  - If `score != SCORE_MAX`, then `score` ← BCD+1 and `score_tick` ← 1.
  - At `SCORE_MAX`, the score holds and no tick is produced.
- BCD increment: ones 9→0 carries into tens; tens 9→0 carries into hundreds. No invalid nibble (>9) is ever stored.
- `new_best` ← 1 when the incremented score > `best_at_start`. Packed BCD compares correctly as unsigned binary.
- End edge: `prev_scene==PLAYING && scene!=PLAYING`.
  - If `score > best`, then `best` ← `score`.
  - `score` is held so that `view` can display it on the GAMEOVER screen.
- GAMEOVER→SPLASH (a future restart path): `score` is held until the next start edge.
- Outside PLAYING, `pipes` is ignored except for tracking `prev_pos`.

## Timing

- Reset values (asynchronous, immediate): `score_bcd`=0, `best_bcd`=0, `score_tick`=0, `new_best`=0, `prev_scene`=SPLASH, `prev_pos`=0xFF, `best_at_start`=0.
- Latency:
  - `score_bcd` and `score_tick` update on the first clock edge after the cycle in which `lead_pos==PASS_COL` first appears, i.e. 1 cycle.
  - `best_bcd` updates 1 cycle after `scene` leaves PLAYING.
- `score_tick` is high for exactly 1 cycle per increment.
- All outputs are registered; there is no combinational input→output path.
- Reset mid-game: all state clears at once, including `best`. Scoring resumes only after a fresh SPLASH→PLAYING edge is observed.

## Structure

- Shared package `flappy_pkg`:
  - Scene constants `SCENE_SPLASH`/`PLAYING`/`GAMEOVER`
  - `BIRD_COL`, `N_PIPE`
  - Pipe record field offsets (POS 23:16, MAX 15:8, MIN 7:0)
  - `controller`, `view` and `score_keeper` all import it.
- Sub-module `bcd_inc3`: combinational 3-digit packed-BCD incrementer with saturation flag, inputs `d[11:0]`, outputs `q[11:0]` and `sat`. Reused later by `view` for score rendering.
- Top-level edit in `main`: instantiate after `controller`, and wire `score_bcd`/`best_bcd` into `view`.

## Test plan

- Reset, hold SPLASH with `lead_pos`=3 → no tick, score 0, best 0, all outputs 0.
- SPLASH→PLAYING, then step `lead_pos` 5,5,5,4,4,4,3,3,3,2 → exactly one tick, score 12'h001 one cycle after the first 3.
- Preload score 12'h099 via 99 pass events, then one more → 12'h100. Ones and tens carry; no nibble ever >9.
- Reach 12'h999, then another pass → score stays 12'h999 and `score_tick` stays 0.
- Game 1 scores 5 and then GAMEOVER → best=5. Restart and score 3, GAMEOVER → best stays 5 and `new_best`=0. Restart and score 6 → `new_best` rises at the 6th tick, and best=6 after GAMEOVER.
- Assert `rst` mid-PLAYING with score 4 → all outputs 0 immediately. Passes while still in PLAYING without a new start edge → no score.
